hilo_muldiv_unit: RTL and testbench

Iterative multiply/divide engine that owns the architectural HI and LO registers. It executes MULT, MULTU, MADD, MSUB, DIV, DIVU, MTHI and MTLO over multiple cycles with a start/busy/done handshake. Its HI/LO outputs drive the ALU's `ALUhi`/`ALUlo` inputs, which MFHI/MFLO read. The pipeline stalls on `Busy` so the ALU never reads partial results.

---
 rtl/hilo_muldiv_unit.sv | 204 ++++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide engine owning the architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, start/busy/done handshake.
module hilo_muldiv_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Done,
  output logic        DivByZero,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [2:0]  o_dbg_state
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b010;
  localparam logic [2:0] OP_MSUB  = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_DIVU  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_ACC  = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [2:0]  r_op;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [63:0] r_hilo_q;
  logic [63:0] r_acc;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_quot;
  logic [31:0] r_rem;
  logic [31:0] r_divs;
  logic [4:0]  r_cnt;
  logic        r_neg;
  logic        r_rem_neg;
  logic        r_bzero;
  logic        r_done;
  logic        r_dbz;

  logic        w_accept;
  logic        w_signed_op;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_is_div;
  logic        w_last_iter;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_diff;
  logic [63:0] w_prod_signed;
  logic [31:0] w_quot_final;
  logic [31:0] w_rem_final;

  // A request is only taken when fully idle and the previous Done has cleared.
  assign w_accept    = (r_state == ST_IDLE) && Start && !r_done;
  assign w_signed_op = (Op == OP_MULT) || (Op == OP_MADD) || (Op == OP_MSUB) || (Op == OP_DIV);
  assign w_a_neg     = w_signed_op && A[31];
  assign w_b_neg     = w_signed_op && B[31];
  assign w_a_mag     = w_a_neg ? (32'd0 - A) : A;
  assign w_b_mag     = w_b_neg ? (32'd0 - B) : B;
  assign w_is_div    = (Op == OP_DIV) || (Op == OP_DIVU);
  assign w_last_iter = (r_cnt == 5'd31);

  // Restoring step: remainder never exceeds the divisor, so the low 32 bits suffice.
  assign w_shift = {r_rem, r_quot[31]};
  assign w_ge    = (w_shift >= {1'b0, r_divs});
  assign w_diff  = w_shift[31:0] - r_divs;

  assign w_prod_signed = r_neg ? (64'd0 - r_acc) : r_acc;
  assign w_quot_final  = r_neg ? (32'd0 - r_quot) : r_quot;
  assign w_rem_final   = r_rem_neg ? (32'd0 - r_rem) : r_rem;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if ((Op == OP_MTHI) || (Op == OP_MTLO)) w_next_state = ST_IDLE;
          else if (w_is_div)                      w_next_state = (B == 32'd0) ? ST_FIN : ST_DIV;
          else                                    w_next_state = ST_MUL;
        end
      end
      ST_MUL: begin
        if (w_last_iter)
          w_next_state = ((r_op == OP_MADD) || (r_op == OP_MSUB)) ? ST_ACC : ST_FIN;
      end
      ST_DIV:  if (w_last_iter) w_next_state = ST_FIN;
      ST_ACC:  w_next_state = ST_FIN;
      ST_FIN:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    Busy        = (r_state != ST_IDLE);
    Done        = r_done;
    DivByZero   = r_dbz;
    HI          = r_hi;
    LO          = r_lo;
    o_dbg_state = r_state;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_op      <= 3'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_hilo_q  <= 64'd0;
      r_acc     <= 64'd0;
      r_mcand   <= 64'd0;
      r_mplier  <= 32'd0;
      r_quot    <= 32'd0;
      r_rem     <= 32'd0;
      r_divs    <= 32'd0;
      r_cnt     <= 5'd0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_bzero   <= 1'b0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op      <= Op;
            r_hilo_q  <= {r_hi, r_lo};
            r_acc     <= 64'd0;
            r_mcand   <= {32'd0, w_a_mag};
            r_mplier  <= w_b_mag;
            r_quot    <= w_a_mag;
            r_rem     <= 32'd0;
            r_divs    <= w_b_mag;
            r_cnt     <= 5'd0;
            r_neg     <= w_a_neg ^ w_b_neg;
            r_rem_neg <= w_a_neg;
            r_bzero   <= w_is_div && (B == 32'd0);
            if (Op == OP_MTHI) begin
              r_hi   <= A;
              r_done <= 1'b1;
            end else if (Op == OP_MTLO) begin
              r_lo   <= A;
              r_done <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= {r_mcand[62:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[31:1]};
          r_cnt    <= r_cnt + 5'd1;
        end
        ST_DIV: begin
          r_rem  <= w_ge ? w_diff : w_shift[31:0];
          r_quot <= {r_quot[30:0], w_ge};
          r_cnt  <= r_cnt + 5'd1;
        end
        ST_ACC: begin
          r_acc <= (r_op == OP_MADD) ? (r_hilo_q + w_prod_signed) : (r_hilo_q - w_prod_signed);
        end
        ST_FIN: begin
          r_done <= 1'b1;
          case (r_op)
            OP_MULT, OP_MULTU: {r_hi, r_lo} <= w_prod_signed;
            OP_MADD, OP_MSUB:  {r_hi, r_lo} <= r_acc;
            OP_DIV, OP_DIVU: begin
              if (r_bzero) begin
                r_dbz <= 1'b1;
              end else begin
                r_lo <= w_quot_final;
                r_hi <= w_rem_final;
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit: latency, HI/LO results,
// divide-by-zero, dropped requests while busy, and asynchronous reset mid-operation.
module tb_hilo_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic        DivByZero;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  hilo_muldiv_unit dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .Op          (Op),
    .A           (A),
    .B           (B),
    .Busy        (Busy),
    .Done        (Done),
    .DivByZero   (DivByZero),
    .HI          (HI),
    .LO          (LO),
    .o_dbg_state (dbg_state)
  );

  always #5 Clk = ~Clk;

  // Issues one request and measures the edge index (edge 0 = accept) after which Done is seen.
  // Also notes any HI/LO movement or wrong Busy level before Done.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output bit early, output bit busy_bad, output bit dbz);
    logic [31:0] hi0;
    logic [31:0] lo0;
    logic        exp_busy;
    @(negedge Clk);
    hi0 = HI;
    lo0 = LO;
    exp_busy = (op != 3'b110) && (op != 3'b111);
    Op = op; A = a; B = b; Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    lat = -1; early = 1'b0; busy_bad = 1'b0; dbz = 1'b0;
    for (int k = 0; k < 60 && lat < 0; k++) begin
      @(negedge Clk);
      if (Done === 1'b1) begin
        lat = k;
        dbz = DivByZero;
        if (Busy !== 1'b0) busy_bad = 1'b1;
      end else begin
        if (HI !== hi0 || LO !== lo0) early = 1'b1;
        if (Busy !== exp_busy) busy_bad = 1'b1;
        @(posedge Clk);
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Op = 3'd0; A = 32'd0; B = 32'd0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checks++; if (HI !== 32'd0)        begin errors++; $display("FAIL reset_hi got %h want 0", HI); end
    checks++; if (LO !== 32'd0)        begin errors++; $display("FAIL reset_lo got %h want 0", LO); end
    checks++; if (Busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
    checks++; if (Done !== 1'b0)       begin errors++; $display("FAIL reset_done got %b want 0", Done); end
    checks++; if (DivByZero !== 1'b0)  begin errors++; $display("FAIL reset_dbz got %b want 0", DivByZero); end
    Reset = 1'b0;
  endtask

  task automatic test_mult();
    int lat; bit early, bb, dbz;
    run_op(3'b000, 32'hFFFFFFFD, 32'd5, lat, early, bb, dbz);
    checks++; if (lat !== 33)            begin errors++; $display("FAIL mult_latency got %0d want 33", lat); end
    checks++; if (HI !== 32'hFFFFFFFF)   begin errors++; $display("FAIL mult_hi got %h want ffffffff", HI); end
    checks++; if (LO !== 32'hFFFFFFF1)   begin errors++; $display("FAIL mult_lo got %h want fffffff1", LO); end
    checks++; if (early !== 1'b0)        begin errors++; $display("FAIL mult_hold got %b want 0", early); end
    checks++; if (bb !== 1'b0)           begin errors++; $display("FAIL mult_busy got %b want 0", bb); end
    @(negedge Clk);
    checks++; if (Done !== 1'b0)         begin errors++; $display("FAIL done_pulse got %b want 0", Done); end
  endtask

  task automatic test_multu();
    int lat; bit early, bb, dbz;
    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, early, bb, dbz);
    checks++; if (HI !== 32'hFFFFFFFE)   begin errors++; $display("FAIL multu_hi got %h want fffffffe", HI); end
    checks++; if (LO !== 32'h00000001)   begin errors++; $display("FAIL multu_lo got %h want 1", LO); end
    run_op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, early, bb, dbz);
    checks++; if (HI !== 32'd0)          begin errors++; $display("FAIL mult_m1_hi got %h want 0", HI); end
    checks++; if (LO !== 32'd1)          begin errors++; $display("FAIL mult_m1_lo got %h want 1", LO); end
  endtask

  task automatic test_madd_msub();
    int lat; bit early, bb, dbz;
    run_op(3'b111, 32'd10, 32'd0, lat, early, bb, dbz);
    checks++; if (lat !== 0)             begin errors++; $display("FAIL mtlo_latency got %0d want 0", lat); end
    checks++; if (bb !== 1'b0)           begin errors++; $display("FAIL mtlo_busy got %b want 0", bb); end
    checks++; if (LO !== 32'd10)         begin errors++; $display("FAIL mtlo_lo got %h want a", LO); end
    run_op(3'b010, 32'd2, 32'd3, lat, early, bb, dbz);
    checks++; if (lat !== 34)            begin errors++; $display("FAIL madd_latency got %0d want 34", lat); end
    checks++; if (HI !== 32'd0)          begin errors++; $display("FAIL madd_hi got %h want 0", HI); end
    checks++; if (LO !== 32'd16)         begin errors++; $display("FAIL madd_lo got %h want 10", LO); end
    run_op(3'b110, 32'd0, 32'd0, lat, early, bb, dbz);
    run_op(3'b111, 32'd0, 32'd0, lat, early, bb, dbz);
    run_op(3'b011, 32'd1, 32'd1, lat, early, bb, dbz);
    checks++; if (HI !== 32'hFFFFFFFF)   begin errors++; $display("FAIL msub_hi got %h want ffffffff", HI); end
    checks++; if (LO !== 32'hFFFFFFFF)   begin errors++; $display("FAIL msub_lo got %h want ffffffff", LO); end
  endtask

  task automatic test_div();
    int lat; bit early, bb, dbz;
    run_op(3'b100, 32'hFFFFFFF9, 32'd2, lat, early, bb, dbz);
    checks++; if (lat !== 33)            begin errors++; $display("FAIL div_latency got %0d want 33", lat); end
    checks++; if (LO !== 32'hFFFFFFFD)   begin errors++; $display("FAIL div_lo got %h want fffffffd", LO); end
    checks++; if (HI !== 32'hFFFFFFFF)   begin errors++; $display("FAIL div_hi got %h want ffffffff", HI); end
    checks++; if (dbz !== 1'b0)          begin errors++; $display("FAIL div_dbz got %b want 0", dbz); end
    run_op(3'b101, 32'd7, 32'd0, lat, early, bb, dbz);
    checks++; if (lat !== 1)             begin errors++; $display("FAIL divz_latency got %0d want 1", lat); end
    checks++; if (dbz !== 1'b1)          begin errors++; $display("FAIL divz_flag got %b want 1", dbz); end
    checks++; if (LO !== 32'hFFFFFFFD)   begin errors++; $display("FAIL divz_lo got %h want fffffffd", LO); end
    checks++; if (HI !== 32'hFFFFFFFF)   begin errors++; $display("FAIL divz_hi got %h want ffffffff", HI); end
    run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, lat, early, bb, dbz);
    checks++; if (LO !== 32'h80000000)   begin errors++; $display("FAIL divovf_lo got %h want 80000000", LO); end
    checks++; if (HI !== 32'd0)          begin errors++; $display("FAIL divovf_hi got %h want 0", HI); end
    run_op(3'b101, 32'd100, 32'd7, lat, early, bb, dbz);
    checks++; if (LO !== 32'd14)         begin errors++; $display("FAIL divu_lo got %h want e", LO); end
    checks++; if (HI !== 32'd2)          begin errors++; $display("FAIL divu_hi got %h want 2", HI); end
  endtask

  task automatic test_ignore_start();
    int k;
    bit seen;
    @(negedge Clk);
    Op = 3'b000; A = 32'd6; B = 32'd7; Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    Op = 3'b110; A = 32'hDEADBEEF; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    seen = 1'b0;
    for (k = 0; k < 60 && !seen; k++) begin
      @(negedge Clk);
      if (Done === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1)         begin errors++; $display("FAIL ign_done got %b want 1", seen); end
    checks++; if (HI !== 32'd0)          begin errors++; $display("FAIL ign_hi got %h want 0", HI); end
    checks++; if (LO !== 32'd42)         begin errors++; $display("FAIL ign_lo got %h want 2a", LO); end
    repeat (4) @(negedge Clk);
    checks++; if (HI !== 32'd0)          begin errors++; $display("FAIL ign_noqueue got %h want 0", HI); end
  endtask

  task automatic test_reset_midop();
    int lat; bit early, bb, dbz;
    @(negedge Clk);
    Op = 3'b000; A = 32'h12345; B = 32'h777; Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    repeat (10) @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    checks++; if (HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("FAIL rstmid_hilo got %h_%h want 0_0", HI, LO); end
    checks++; if (Busy !== 1'b0)         begin errors++; $display("FAIL rstmid_busy got %b want 0", Busy); end
    checks++; if (Done !== 1'b0 || DivByZero !== 1'b0) begin errors++; $display("FAIL rstmid_flags got %b%b want 00", Done, DivByZero); end
    @(negedge Clk);
    Reset = 1'b0;
    run_op(3'b000, 32'd4, 32'd4, lat, early, bb, dbz);
    checks++; if (lat !== 33)            begin errors++; $display("FAIL rst_mult_latency got %0d want 33", lat); end
    checks++; if (LO !== 32'd16)         begin errors++; $display("FAIL rst_mult_lo got %h want 10", LO); end
    checks++; if (HI !== 32'd0)          begin errors++; $display("FAIL rst_mult_hi got %h want 0", HI); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_madd_msub();
    test_div();
    test_ignore_start();
    test_reset_midop();
    repeat (2) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
